// File: rtl/dmem_bytelane_sram_if.sv
// Request/response bus between the load/store unit (master) and the data memory (slave).
// The misalign_err wire exists only when DMEM_MISALIGN_CHECK_EN is defined.
interface dmem_bytelane_sram_if #(
  parameter int A_BITS = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [A_BITS+1:0] req_addr;
  logic [2:0]        req_funct3;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic              misalign_err;
`endif

  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
`ifdef DMEM_MISALIGN_CHECK_EN
    , input misalign_err
`endif
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
`ifdef DMEM_MISALIGN_CHECK_EN
    , output misalign_err
`endif
  );
endinterface

// File: rtl/dmem_bytelane_sram.sv
// Byte-lane data memory for the load/store unit: sized/sign-extended loads,
// byte/half/word stores, valid/ready requests with a registered 1-cycle response,
// and a post-reset clear sequencer that zeroes one word per cycle.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (flags and suppresses misaligned
// halfword/word accesses instead of ignoring the unused low address bits).
module dmem_bytelane_sram #(
  parameter int A_BITS     = 10,
  parameter int MEMSIZE    = 1024,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  dmem_bytelane_sram_if.slave   bus,
  output logic                  init_done
);

  localparam int IDX_W = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEMSIZE - 1);

  typedef enum logic [0:0] {S_INIT, S_RUN} state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  cnt_q;
  logic              req_ready_q;
  logic              init_done_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic              misalign_q;
`endif

  logic [31:0]       mem_q [MEMSIZE];

  logic [A_BITS-1:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic [1:0]        off;
  logic              in_range;
  logic              accept;
  logic              misalign_d;
  logic [31:0]       rd_word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       rsp_rdata_d;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;

  assign word_idx = bus.req_addr[A_BITS+1:2];
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign off      = bus.req_addr[1:0];
  assign accept   = bus.req_valid && req_ready_q;

  // Range check only exists when the address space is larger than the array.
  if (MEMSIZE >= (2 ** A_BITS)) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = ({1'b0, word_idx} < (A_BITS+1)'(MEMSIZE));
  end

  // Decode the request into a lane-masked write and an extended load result.
  // NOTE: combinational logic uses blocking '=' and every output gets a default
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    wr_en       = 1'b0;
    wr_idx      = mem_idx;
    wr_be       = 4'h0;
    wr_data     = 32'h0;
    rsp_rdata_d = 32'h0;
    misalign_d  = 1'b0;
    rd_word     = in_range ? mem_q[mem_idx] : 32'h0;
    byte_sel    = rd_word[{off, 3'b000} +: 8];
    half_sel    = off[1] ? rd_word[31:16] : rd_word[15:0];
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign_d  = ((bus.req_funct3[1:0] == 2'b01) && off[0]) ||
                  ((bus.req_funct3 == 3'b010) && (off != 2'b00));
`endif
    if (state_q == S_INIT) begin
      wr_en  = nrst;
      wr_idx = cnt_q;
      wr_be  = 4'hF;
    end else if (accept && !misalign_d) begin
      if (bus.req_we) begin
        wr_en = nrst && in_range;
        case (bus.req_funct3)
          3'b000, 3'b100: begin
            wr_be   = 4'b0001 << off;
            wr_data = {4{bus.req_wdata[7:0]}};
          end
          3'b001, 3'b101: begin
            wr_be   = off[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{bus.req_wdata[15:0]}};
          end
          3'b010: begin
            wr_be   = 4'hF;
            wr_data = bus.req_wdata;
          end
          default: wr_be = 4'h0;
        endcase
      end else begin
        case (bus.req_funct3)
          3'b000:  rsp_rdata_d = {{24{byte_sel[7]}}, byte_sel};
          3'b001:  rsp_rdata_d = {{16{half_sel[15]}}, half_sel};
          3'b010:  rsp_rdata_d = rd_word;
          3'b100:  rsp_rdata_d = {24'h0, byte_sel};
          3'b101:  rsp_rdata_d = {16'h0, half_sel};
          default: rsp_rdata_d = 32'h0;
        endcase
      end
    end
  end

  // Clear/run sequencer with registered handshake and response outputs.
  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= (INIT_CLEAR != 0) ? S_INIT : S_RUN;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
`ifdef DMEM_MISALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= accept;
      rsp_rdata_q <= accept ? rsp_rdata_d : 32'h0;
`ifdef DMEM_MISALIGN_CHECK_EN
      misalign_q  <= accept && misalign_d;
`endif
      case (state_q)
        S_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_q     <= S_RUN;
            req_ready_q <= 1'b1;
            init_done_q <= 1'b1;
          end
        end
        default: begin
          req_ready_q <= 1'b1;
          init_done_q <= 1'b1;
        end
      endcase
    end
  end

  // Single write port: lane-masked store or clear-sequencer zero write.
  // NOTE: the array deliberately has no reset branch; zeroing is done by the
  // clear sequencer so the storage can map onto a plain SRAM macro.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_be[l]) mem_q[wr_idx][8*l +: 8] <= wr_data[8*l +: 8];
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign init_done     = init_done_q;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign bus.misalign_err = misalign_q;
`endif

endmodule

// File: doc/dmem_bytelane_sram.md
Name: dmem_bytelane_sram

Overview:
- Parametrised data memory for the RISC-V core's load/store unit; next generation of the word-only SRAM.
- Adds byte/halfword stores through byte-lane enables, and sign/zero-extended sized loads decoded from funct3.
- Adds a valid/ready request handshake with a registered, 1-cycle response.
- Replaces the single-cycle reset clear with a synchronous clear sequencer that walks the array one word per cycle.

Parameters:
- A_BITS, 10, word-address width; the byte address is A_BITS+2 bits.
- MEMSIZE, 1024, number of 32-bit words; must satisfy MEMSIZE <= 2**A_BITS.
- INIT_CLEAR, 1, 1 = zero the array after reset; 0 = skip the clear, ready immediately after reset.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- nrst  input  1  synchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  A_BITS+2  byte address.
- req_funct3  input  3  RISC-V size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  response strobe, one cycle per accepted request.
- rsp_rdata  output  32  load result, extended to 32 bits.
- init_done  output  1  high once the clear sequence has finished.
- misalign_err  output  1  misalignment flag; exists only with the optional feature.

Behaviour:
- Reset is sampled on the rising edge of clk while nrst=0.
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, misalign_err=0.
  - Clear counter=0.
  - FSM goes to S_INIT if INIT_CLEAR=1, otherwise S_RUN.
- FSM S_INIT:
  - Writes 0 to word[cnt] each cycle and increments cnt.
  - When cnt==MEMSIZE-1, the next state is S_RUN and init_done=1 from that cycle on.
  - The clear takes exactly MEMSIZE cycles.
  - req_ready=0 throughout; requests are ignored.
- FSM S_RUN:
  - req_ready=1 every cycle.
  - A request is accepted when req_valid && req_ready.
  - Accepted at edge N: rsp_valid=1 in cycle N+1 for exactly one cycle.
  - Back-to-back accepts give a continuous rsp_valid.
  - Stores also produce the rsp_valid pulse, with rsp_rdata=0.
- rsp_rdata is forced to 0 in any cycle where rsp_valid=0.
- Word index = req_addr[A_BITS+1:2]. Byte offset = req_addr[1:0].
- Store lane rules:
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all 4 lanes.
  - Unwritten lanes are preserved.
- Load rules: the word is read at accept, then the selected lane(s) are shifted down.
  - LB and LH sign-extend from bit 7 and bit 15 respectively.
  - LBU and LHU zero-extend.
  - LW returns the word unchanged.
- Reserved funct3 (011, 110, 111): no memory write; rsp_valid still pulses with rsp_rdata=0.
- Out-of-range word index (>= MEMSIZE): write suppressed; load returns 0; rsp_valid still pulses.
- Store at N followed by a load of the same word at N+1 returns the updated data (one port, no hazard window).
- Default alignment handling (feature off):
  - The low address bits a size does not use are ignored.
  - LH at offset 3 behaves as offset 2; LW at any offset behaves as offset 0.
- Reset mid-operation:
  - Any pending rsp_valid is dropped.
  - The clear restarts from cnt=0 (INIT_CLEAR=1).
  - Memory contents are undefined until init_done rises again.
- With INIT_CLEAR=0: init_done=1 and req_ready=1 from the first cycle after reset deasserts; memory contents are not cleared.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - The misalign_err port exists.
  - Halfword access with addr[0]=1, or word access with addr[1:0]!=0, is accepted, writes nothing, and returns rsp_valid=1 with rsp_rdata=0 and misalign_err=1 in the same cycle.
  - misalign_err=0 in every other cycle.
- Not defined: the port is absent and the default alignment handling above applies.

Test Plan:
- Reset + clear: nrst low 2 cycles, INIT_CLEAR=1, MEMSIZE=16 -> req_ready=0 for 16 cycles, then init_done=1 and req_ready=1; an LW of every word returns 0x00000000.
- Byte-lane store:
  - SW 0x11223344 @0x20, then SB 0xAA @0x21, then LW @0x20 -> 0x1122AA44.
  - SH 0xBEEF @0x22, then LW @0x20 -> 0xBEEFAA44.
- Extension: word @0x40 = 0x80FF7F80.
  - LB @0x40 -> 0xFFFFFF80; LBU @0x40 -> 0x00000080.
  - LH @0x42 -> 0xFFFF80FF; LHU @0x42 -> 0x000080FF.
- Throughput/latency: 8 back-to-back LW with req_valid held high -> rsp_valid high for 8 consecutive cycles, each 1 cycle after its accept; SW @0x8 then LW @0x8 on the next cycle -> new data.
- Boundaries:
  - Reserved funct3=011 store -> memory unchanged, response rdata=0.
  - Word index MEMSIZE (out of range) -> load returns 0.
  - nrst pulsed at clear cycle 5 -> the clear restarts and init_done rises MEMSIZE cycles after reset release.
- Misalignment (DMEM_MISALIGN_CHECK_EN defined):
  - SW 0xDEADBEEF @0x31 -> misalign_err=1, rsp_rdata=0; LW @0x30 is unchanged.
  - Macro undefined: the same SW writes 0xDEADBEEF to word 0x30.
